sum_splitter: RTL and testbench

SUM_SPLITTER -- requirements
Module: sum_splitter

---
 rtl/sum_split_pkg.sv | 25 ++
 rtl/sum_split_skid.sv | 90 +++++++++
 rtl/sum_splitter.sv | 96 +++++++++
 tb/tb_sum_splitter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sum_split_pkg.sv
// sum_split_pkg
// Shared definitions for the sum splitter: default operand width, skid buffer
// state encoding, statistics counter width and a saturating increment helper.
package sum_split_pkg;

    localparam int SUM_SPLIT_DATA_W = 8;
    localparam int SUM_SPLIT_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [SUM_SPLIT_CNT_W-1:0] sat_inc(
        input logic [SUM_SPLIT_CNT_W-1:0] cnt
    );
        if (&cnt) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

endpackage

// File: rtl/sum_split_skid.sv
// sum_split_skid
// Two-entry skid buffer with registered outputs and a registered ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i    upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o downstream handshake and payload
// out_data_o is held while out_valid_o=1 and out_ready_i=0. in_ready_o depends
// only on registered state, so there is no combinational out_ready->in_ready path.
module sum_split_skid
    import sum_split_pkg::*;
#(
    parameter int PAYLOAD_W = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_data_o
);

    skid_state_e          state_q, state_d;
    logic [PAYLOAD_W-1:0] out_q, out_d;
    logic [PAYLOAD_W-1:0] spare_q, spare_d;
    logic                 in_ready_q;
    logic                 accept;
    logic                 xfer;

    assign out_valid_o = (state_q != ST_EMPTY);
    assign in_ready_o  = in_ready_q;
    assign out_data_o  = out_q;

    // in_ready_q is 0 in TWO, so TWO never sees an accept.
    assign accept = in_valid_i & in_ready_q;
    assign xfer   = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        spare_d = spare_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_d   = in_data_i;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    out_d = in_data_i;
                end else if (accept) begin
                    spare_d = in_data_i;
                    state_d = ST_TWO;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (xfer) begin
                    out_d   = spare_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            out_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    // The skid entry is only ever read in TWO, after being written, so it
    // needs no reset.
    always_ff @(posedge clk) begin
        spare_q <= spare_d;
    end

endmodule

// File: rtl/sum_splitter.sv
// sum_splitter
// Recovers operand b from an adder result: b = sum_in - a_in. Results that do
// not fit in DATA_W unsigned bits are flagged with err_o and b_o forced to 0;
// flagged results still flow through the handshake like any other.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid, in_ready            upstream handshake
//   sum_in [DATA_W:0], a_in       adder sum and known operand
//   out_valid, out_ready          downstream handshake
//   b_o [DATA_W-1:0], err_o       recovered operand and range error
// Optional (macro SUM_SPLIT_STATS_EN):
//   cnt_ok_o, cnt_err_o [15:0]    saturating counts of transferred results
//                                 with err=0 / err=1, cleared by rst
module sum_splitter
    import sum_split_pkg::*;
#(
    parameter int DATA_W = SUM_SPLIT_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W:0]            sum_in,
    input  logic [DATA_W-1:0]          a_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          b_o,
`ifdef SUM_SPLIT_STATS_EN
    output logic [SUM_SPLIT_CNT_W-1:0] cnt_ok_o,
    output logic [SUM_SPLIT_CNT_W-1:0] cnt_err_o,
`endif
    output logic                       err_o
);

    logic signed [DATA_W+1:0] diff;
    logic                     err;
    logic [DATA_W-1:0]        b_val;
    logic [DATA_W:0]          out_payload;

    // Both operands zero-extended into a signed DATA_W+2 frame. A set sign
    // bit means diff<0; bit DATA_W set on a non-negative value means
    // diff > 2^DATA_W-1.
    assign diff  = $signed({1'b0, sum_in}) - $signed({2'b00, a_in});
    assign err   = diff[DATA_W+1] | diff[DATA_W];
    assign b_val = err ? '0 : diff[DATA_W-1:0];

    sum_split_skid #(
        .PAYLOAD_W (DATA_W + 1)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   ({err, b_val}),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_payload)
    );

    assign err_o = out_payload[DATA_W];
    assign b_o   = out_payload[DATA_W-1:0];

`ifdef SUM_SPLIT_STATS_EN
    logic [SUM_SPLIT_CNT_W-1:0] cnt_ok_q, cnt_ok_d;
    logic [SUM_SPLIT_CNT_W-1:0] cnt_err_q, cnt_err_d;
    logic                       xfer;

    assign xfer = out_valid & out_ready;

    always_comb begin
        cnt_ok_d  = cnt_ok_q;
        cnt_err_d = cnt_err_q;
        if (xfer) begin
            if (err_o) begin
                cnt_err_d = sat_inc(cnt_err_q);
            end else begin
                cnt_ok_d = sat_inc(cnt_ok_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
        end else begin
            cnt_ok_q  <= cnt_ok_d;
            cnt_err_q <= cnt_err_d;
        end
    end

    assign cnt_ok_o  = cnt_ok_q;
    assign cnt_err_o = cnt_err_q;
`endif

endmodule

// File: tb/tb_sum_splitter.sv
module tb_sum_splitter;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW:0]   sum_in;
    logic [DW-1:0] a_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] b_o;
    logic          err_o;
`ifdef SUM_SPLIT_STATS_EN
    logic [15:0]   cnt_ok_o;
    logic [15:0]   cnt_err_o;
`endif

    int n_total;
    int n_pass;

    typedef struct {
        logic [DW:0]   sum;
        logic [DW-1:0] a;
        logic [DW-1:0] exp_b;
        logic          exp_err;
    } vec_t;

    vec_t vecs[9];

    sum_splitter #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .a_in      (a_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b_o       (b_o),
`ifdef SUM_SPLIT_STATS_EN
        .cnt_ok_o  (cnt_ok_o),
        .cnt_err_o (cnt_err_o),
`endif
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum_in    = '0;
        a_in      = '0;

        vecs[0] = '{9'd300, 8'd100, 8'd200, 1'b0};
        vecs[1] = '{9'd100, 8'd150, 8'd0,   1'b1};
        vecs[2] = '{9'd511, 8'd0,   8'd0,   1'b1};
        vecs[3] = '{9'd510, 8'd255, 8'd255, 1'b0};
        vecs[4] = '{9'd255, 8'd0,   8'd255, 1'b0};
        vecs[5] = '{9'd256, 8'd0,   8'd0,   1'b1};
        vecs[6] = '{9'd0,   8'd0,   8'd0,   1'b0};
        vecs[7] = '{9'd0,   8'd1,   8'd0,   1'b1};
        vecs[8] = '{9'd256, 8'd1,   8'd255, 1'b0};

        // Reset state
        #1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_b",         32'(b_o),       32'd0);
        chk("rst_err",       32'(err_o),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready",  32'(in_ready),  32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Streaming table: one result per cycle, in_ready stays high
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            sum_in   = vecs[i].sum;
            a_in     = vecs[i].a;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_b", i),     32'(b_o),       32'(vecs[i].exp_b));
            chk($sformatf("vec%0d_err", i),   32'(err_o),     32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_ready", i), 32'(in_ready),  32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: fill both entries, third input blocked
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sum_in    = 9'd10;
        a_in      = 8'd1;
        tick();
        chk("bp1_ready", 32'(in_ready), 32'd1);
        chk("bp1_b",     32'(b_o),      32'd9);
        sum_in = 9'd20;
        a_in   = 8'd2;
        tick();
        chk("bp2_ready", 32'(in_ready),  32'd0);
        chk("bp2_valid", 32'(out_valid), 32'd1);
        chk("bp2_b",     32'(b_o),       32'd9);
        sum_in = 9'd30;
        a_in   = 8'd3;
        tick();
        chk("bp3_ready_low", 32'(in_ready), 32'd0);
        chk("bp3_hold_b",    32'(b_o),      32'd9);
        chk("bp3_hold_err",  32'(err_o),    32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp4_b",     32'(b_o),      32'd18);
        chk("bp4_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp5_b",     32'(b_o),       32'd27);
        chk("bp5_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("bp6_empty", 32'(out_valid), 32'd0);

        // Reset while holding two entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sum_in    = 9'd50;
        a_in      = 8'd5;
        tick();
        sum_in = 9'd60;
        tick();
        chk("two_ready_low", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready),  32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("midrst_stale%0d", i), 32'(out_valid), 32'd0);
        end

`ifdef SUM_SPLIT_STATS_EN
        chk("cnt_ok_clr",  32'(cnt_ok_o),  32'd0);
        chk("cnt_err_clr", 32'(cnt_err_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            sum_in   = vecs[i].sum;
            a_in     = vecs[i].a;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("cnt_ok_3",  32'(cnt_ok_o),  32'd3);
        chk("cnt_err_2", 32'(cnt_err_o), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        in_valid = 1'b1;
        sum_in   = 9'd20;
        a_in     = 8'd2;
        for (int i = 0; i < 65540; i++) begin
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("cnt_ok_sat", 32'(cnt_ok_o),  32'hFFFF);
        chk("cnt_err_0",  32'(cnt_err_o), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
